frame_sipo_buf: RTL and testbench

//  Parametrised serial-to-parallel frame collector between the FIR output stream and the FFT.

---
 rtl/sipo_pkg.sv | 12 +
 rtl/sipo_slot_bank.sv | 41 ++++
 rtl/frame_sipo_buf.sv | 102 ++++++++++
 tb/tb_frame_sipo_buf.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/sipo_pkg.sv
// Shared constants and helpers for the frame serial-to-parallel collector.
// Gap-handling selectors and the slot-index to bit-offset mapping of a frame bus.
package sipo_pkg;

    localparam int GAP_DISCARD = 0;
    localparam int GAP_HOLD    = 1;

    function automatic int unsigned slot_off(input int unsigned slot, input int unsigned data_w);
        return slot * data_w;
    endfunction

endpackage

// File: rtl/sipo_slot_bank.sv
// Register bank holding the partial frame, one slot written per accepted sample.
// Latency: written slot visible the cycle after the write.
// Backpressure: none, the writer decides when wr_en is asserted.
module sipo_slot_bank
    import sipo_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int SLOTS  = 15,
    parameter int CNT_W  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [CNT_W-1:0]        wr_idx,
    input  logic [DATA_W-1:0]       wr_data,
    output logic [SLOTS*DATA_W-1:0] slots
);

    logic [DATA_W-1:0] mem [SLOTS];
    logic [SLOTS-1:0]  wr_hot;

    for (genvar i = 0; i < SLOTS; i++) begin : g_slot
        assign wr_hot[i] = wr_en & (wr_idx == CNT_W'(i));
        assign slots[slot_off(i, DATA_W) +: DATA_W] = mem[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SLOTS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < SLOTS; i++) begin
                if (wr_hot[i]) begin
                    mem[i] <= wr_data;
                end
            end
        end
    end

endmodule

// File: rtl/frame_sipo_buf.sv
// Collects FRAME_LEN serial samples into one parallel frame on a valid/ready port.
// Latency: frame visible the cycle after its last sample is accepted.
// Backpressure: only the completing sample stalls, while an untaken frame is still held.
module frame_sipo_buf
    import sipo_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int FRAME_LEN = 16,
    parameter int GAP_MODE  = GAP_DISCARD,
    parameter int CNT_W     = $clog2(FRAME_LEN)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    input  logic [DATA_W-1:0]           in_data,
    output logic                        in_ready,
    input  logic                        flush,
    output logic                        frame_valid,
    input  logic                        frame_ready,
    output logic [DATA_W*FRAME_LEN-1:0] frame_data,
    output logic [CNT_W-1:0]            fill_level,
    output logic [7:0]                  frame_cnt,
    output logic                        drop
);

    localparam int               BANK_W = DATA_W * (FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(FRAME_LEN - 1);
    localparam bit               HOLD   = (GAP_MODE == GAP_HOLD);

    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [BANK_W-1:0] bank;
    logic              last;
    logic              accept;
    logic              complete;
    logic              gap;
    logic              drop_nxt;
    logic              frame_valid_nxt;

    assign last     = (cnt == LAST);
    // frame_ready feeds in_ready combinationally so a take and a completion can share an edge.
    assign in_ready = ~flush & ~(last & frame_valid & ~frame_ready);
    assign accept   = in_valid & in_ready;
    assign complete = accept & last;
    assign gap      = ~in_valid & ~HOLD;

    assign fill_level = cnt;

    sipo_slot_bank #(
        .DATA_W (DATA_W),
        .SLOTS  (FRAME_LEN - 1),
        .CNT_W  (CNT_W)
    ) u_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (accept & ~last),
        .wr_idx  (cnt),
        .wr_data (in_data),
        .slots   (bank)
    );

    always_comb begin
        cnt_nxt         = cnt;
        drop_nxt        = 1'b0;
        frame_valid_nxt = frame_valid;
        if (flush) begin
            cnt_nxt  = '0;
            drop_nxt = (cnt != '0);
        end else if (accept) begin
            cnt_nxt = last ? '0 : cnt + CNT_W'(1);
        end else if (gap) begin
            cnt_nxt  = '0;
            drop_nxt = (cnt != '0);
        end
        if (complete) begin
            frame_valid_nxt = 1'b1;
        end else if (frame_ready) begin
            frame_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            drop        <= 1'b0;
            frame_valid <= 1'b0;
            frame_data  <= '0;
            frame_cnt   <= '0;
        end else begin
            cnt         <= cnt_nxt;
            drop        <= drop_nxt;
            frame_valid <= frame_valid_nxt;
            if (complete) begin
                // The completing sample bypasses the bank straight into the top slot.
                frame_data[BANK_W-1:0] <= bank;
                frame_data[slot_off(FRAME_LEN - 1, DATA_W) +: DATA_W] <= in_data;
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_frame_sipo_buf.sv
// Drives a discard-mode and a hold-mode collector with shared stimulus
// and compares both against a per-instance sample-list reference model.
module tb_frame_sipo_buf;
    import sipo_pkg::*;

    localparam int DW = 16;
    localparam int FL = 16;
    localparam int CW = $clog2(FL);
    localparam int FW = DW * FL;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          flush;
    logic          frame_ready;

    logic          rdy_d  [2];
    logic          fv_d   [2];
    logic [FW-1:0] fd_d   [2];
    logic [CW-1:0] fill_d [2];
    logic [7:0]    fc_d   [2];
    logic          drop_d [2];

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state: list of buffered samples, last emitted frame, flags.
    logic [DW-1:0] part [2][FL];
    int            n    [2];
    logic [DW-1:0] outf [2][FL];
    bit            fv   [2];
    int            fcnt [2];
    bit            dr   [2];

    always #5 clk = ~clk;

    frame_sipo_buf #(.DATA_W(DW), .FRAME_LEN(FL), .GAP_MODE(GAP_DISCARD)) u_disc (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy_d[0]),
        .flush(flush), .frame_valid(fv_d[0]), .frame_ready(frame_ready), .frame_data(fd_d[0]),
        .fill_level(fill_d[0]), .frame_cnt(fc_d[0]), .drop(drop_d[0])
    );

    frame_sipo_buf #(.DATA_W(DW), .FRAME_LEN(FL), .GAP_MODE(GAP_HOLD)) u_hold (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy_d[1]),
        .flush(flush), .frame_valid(fv_d[1]), .frame_ready(frame_ready), .frame_data(fd_d[1]),
        .fill_level(fill_d[1]), .frame_cnt(fc_d[1]), .drop(drop_d[1])
    );

    task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            n[m] = 0; fv[m] = 0; fcnt[m] = 0; dr[m] = 0;
            for (int i = 0; i < FL; i++) outf[m][i] = '0;
        end
    endtask

    function automatic bit model_rdy(input int m, input bit fl, input bit fr);
        return !fl && !(n[m] == FL - 1 && fv[m] && !fr);
    endfunction

    task automatic model_edge(input int m, input bit iv, input logic [DW-1:0] id,
                              input bit fl, input bit fr);
        bit rdy  = model_rdy(m, fl, fr);
        bit done = 0;
        dr[m] = 0;
        if (fl) begin
            dr[m] = (n[m] != 0);
            n[m]  = 0;
        end else if (iv) begin
            if (rdy) begin
                part[m][n[m]] = id;
                n[m]++;
                if (n[m] == FL) begin
                    for (int i = 0; i < FL; i++) outf[m][i] = part[m][i];
                    n[m]    = 0;
                    fcnt[m] = (fcnt[m] + 1) % 256;
                    done    = 1;
                end
            end
        end else if (m == 0 && n[m] != 0) begin
            dr[m] = 1;
            n[m]  = 0;
        end
        if (done) fv[m] = 1;
        else if (fr) fv[m] = 0;
    endtask

    task automatic check_outputs();
        logic [FW-1:0] exp;
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < FL; i++) exp[i*DW +: DW] = outf[m][i];
            chk($sformatf("frame_valid[%0d]", m), FW'(fv_d[m]), FW'(fv[m]));
            chk($sformatf("frame_data[%0d]", m), fd_d[m], exp);
            chk($sformatf("fill_level[%0d]", m), FW'(fill_d[m]), FW'(n[m]));
            chk($sformatf("frame_cnt[%0d]", m), FW'(fc_d[m]), FW'(fcnt[m]));
            chk($sformatf("drop[%0d]", m), FW'(drop_d[m]), FW'(dr[m]));
        end
    endtask

    // One clock cycle, entered and left at a falling edge; acc reports the discard instance's in_ready.
    task automatic step(input bit iv, input logic [DW-1:0] id, input bit fl, input bit fr,
                        output bit acc);
        in_valid = iv; in_data = id; flush = fl; frame_ready = fr;
        #1;
        for (int m = 0; m < 2; m++)
            chk($sformatf("in_ready[%0d]", m), FW'(rdy_d[m]), FW'(model_rdy(m, fl, fr)));
        acc = rdy_d[0];
        @(posedge clk);
        for (int m = 0; m < 2; m++) model_edge(m, iv, id, fl, fr);
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        for (int m = 0; m < 2; m++) begin
            chk({tag, "_fv"}, FW'(fv_d[m]), '0);
            chk({tag, "_fd"}, fd_d[m], '0);
            chk({tag, "_fill"}, FW'(fill_d[m]), '0);
            chk({tag, "_fc"}, FW'(fc_d[m]), '0);
            chk({tag, "_drop"}, FW'(drop_d[m]), '0);
        end
    endtask

    initial begin
        bit            acc;
        int            stalls;
        int            k;
        int            c;
        int            drops0;
        int            drops1;
        logic [DW-1:0] samp [32];

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0; frame_ready = 1'b0;
        model_reset();
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // 1: sixteen ramp samples with the consumer always ready
        for (int i = 1; i <= FL; i++) begin
            step(1, DW'(i), 0, 1, acc);
            if (i == FL - 1) chk("t1_not_yet_valid", FW'(fv_d[0]), '0);
        end
        chk("t1_valid", FW'(fv_d[0]), FW'(1));
        chk("t1_slot0", FW'(fd_d[0][0 +: DW]), FW'(16'h0001));
        chk("t1_slot15", FW'(fd_d[0][15*DW +: DW]), FW'(16'h0010));
        chk("t1_frame_cnt", FW'(fc_d[0]), FW'(1));

        // 2: 32 samples, consumer blocked until cycle 40
        step(0, '0, 0, 1, acc);
        for (int i = 0; i < 32; i++) samp[i] = DW'($urandom);
        k = 0; stalls = 0; c = 0;
        while (k < 32 && c < 100) begin
            step(1, samp[k], 0, c >= 40, acc);
            if (acc) k++;
            else stalls++;
            c++;
        end
        chk("t2_done", FW'(k), FW'(32));
        chk("t2_stalls", FW'(stalls), FW'(9));
        chk("t2_frame2_slot0", FW'(fd_d[0][0 +: DW]), FW'(samp[16]));
        chk("t2_frame2_slot15", FW'(fd_d[0][15*DW +: DW]), FW'(samp[31]));

        // 3: five samples, one idle cycle, then a full frame
        step(0, '0, 0, 1, acc);
        drops0 = 0; drops1 = 0;
        for (int i = 0; i < 5; i++) step(1, DW'($urandom), 0, 1, acc);
        step(0, '0, 0, 1, acc);
        drops0 += int'(drop_d[0]); drops1 += int'(drop_d[1]);
        chk("t3_fill_after_gap", FW'(fill_d[0]), '0);
        for (int i = 0; i < FL; i++) begin
            step(1, DW'($urandom), 0, 1, acc);
            drops0 += int'(drop_d[0]); drops1 += int'(drop_d[1]);
        end
        chk("t3_drops_disc", FW'(drops0), FW'(1));
        chk("t3_drops_hold", FW'(drops1), '0);

        // 4: five samples, three idle cycles, eleven samples
        step(1, '0, 1, 1, acc);
        drops1 = 0;
        for (int i = 0; i < 5; i++) step(1, DW'($urandom), 0, 1, acc);
        for (int i = 0; i < 3; i++) begin
            step(0, '0, 0, 1, acc);
            drops1 += int'(drop_d[1]);
        end
        for (int i = 0; i < 11; i++) step(1, DW'($urandom), 0, 1, acc);
        chk("t4_hold_drops", FW'(drops1), '0);
        chk("t4_hold_valid", FW'(fv_d[1]), FW'(1));

        // 5: flush with seven buffered samples while a frame is pending
        step(1, '0, 1, 1, acc);
        for (int i = 0; i < FL + 7; i++) step(1, DW'($urandom), 0, 0, acc);
        step(1, DW'($urandom), 1, 0, acc);
        chk("t5_drop", FW'(drop_d[0]), FW'(1));
        chk("t5_fill", FW'(fill_d[0]), '0);
        chk("t5_pending", FW'(fv_d[0]), FW'(1));

        // 6: asynchronous reset at fill level 9 with a frame pending
        for (int i = 0; i < 9; i++) step(1, DW'($urandom), 0, 0, acc);
        chk("t6_fill9", FW'(fill_d[0]), FW'(9));
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all_zero("t6_async");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < FL; i++) step(1, DW'($urandom), 0, 1, acc);
        chk("t6_frame_cnt", FW'(fc_d[0]), FW'(1));

        // Random traffic with occasional gaps, flushes and consumer stalls
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 9) != 0, DW'($urandom), $urandom_range(0, 29) == 0,
                 $urandom_range(0, 3) != 0, acc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
